ili9341_cmd_sequencer: RTL
==========================

// Module: ili9341_cmd_sequencer
// PURPOSE
//  Sequences ILI9341 bring-up and pixel streaming over the shared SPI byte shifter.
//  Drives the panel hardware reset, then walks the init command ROM and the loop (pixel) ROM.
//  Presents one {dc, byte} at a time to the shifter via load/done and paces the panel delays.
//  Sits between the top-level control and the shifter; owns lcd_rst_n and lcd_dc.
// PARAMETERS
//  N_INIT        48      entries in init ROM; index N_INIT-1 is sent first, index 0 (0xFF) never sent
//  N_LOOP        3       entries in loop ROM; index N_LOOP-1 sent first, wraps after index 0
//  RST_LOW_CYC   1000    cycles lcd_rst_n held low
//  RST_WAIT_CYC  120000  cycles after lcd_rst_n rises before first init byte
//  SLP_WAIT_CYC  600000  cycles after command 0x11 (sleep out) completes before next byte
//  FRAME_BYTES   153600  pixel bytes per frame (240x320x2); frame_tick period
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   async active-low reset
//  start       in   1   level; 1 = run bring-up then stream; 0 in READY/stream = stop at byte boundary
//  rom_sel     out  1   1 = init ROM (INI_COMM), 0 = loop ROM (LOOP_COMM)
//  rom_idx     out  6   ROM index; rom_word returned combinationally the same cycle
//  rom_word    in   10  {flag, dc, byte}; flag ignored here
//  load        out  1   1-cycle pulse: data/lcd_dc valid, shifter starts a byte
//  data        out  8   byte to shifter, held from load until done
//  lcd_dc      out  1   0 = command, 1 = parameter/pixel; held from load until done
//  done        in   1   1-cycle pulse from shifter: byte fully shifted
//  lcd_rst_n   out  1   panel hardware reset, active low
//  init_done   out  1   level: bring-up finished (sticky until reset)
//  busy        out  1   1 in every state except IDLE and READY
//  frame_tick  out  1   1-cycle pulse after every FRAME_BYTES pixel bytes
// BEHAVIOUR
//  Clock clk, reset rst_n: single clock, asynchronous active-low reset.
//  Reset values: state=IDLE, lcd_rst_n=1, load=0, data=0, lcd_dc=0, init_done=0, busy=0,
//   frame_tick=0, rom_sel=1, rom_idx=N_INIT-1, delay/byte counters=0.
//  States:
//   IDLE     : start=1 -> RST_LOW (lcd_rst_n=0, counter cleared).
//   RST_LOW  : RST_LOW_CYC cycles, then lcd_rst_n=1 -> RST_WAIT.
//   RST_WAIT : RST_WAIT_CYC cycles -> INI_LOAD.
//   INI_LOAD : 1 cycle; load=1, {lcd_dc,data}=rom_word[8:0] at rom_idx -> INI_WAIT.
//   INI_WAIT : wait done. On done, if the sent word was {dc=0, 0x11} -> SLP_WAIT;
//              else if rom_idx==1 -> READY, init_done=1; else rom_idx-1 -> INI_LOAD.
//   SLP_WAIT : SLP_WAIT_CYC cycles, rom_idx-1 -> INI_LOAD.
//   READY    : rom_sel=0, rom_idx=N_LOOP-1; start=1 -> PIX_LOAD; start=0 stays.
//   PIX_LOAD : load=1 with loop ROM word -> PIX_WAIT.
//   PIX_WAIT : on done: byte count+1; rom_idx-1, wrapping 0 -> N_LOOP-1;
//              start=1 -> PIX_LOAD, else -> READY.
//  Latency: load asserts the cycle after the state is entered; next load earliest
//   1 cycle after done (one load per done, never overlapped).
//  done outside INI_WAIT/PIX_WAIT is ignored. done coincident with load is ignored.
//  Byte counter: when it reaches FRAME_BYTES-1 and done arrives -> frame_tick=1 for 1 cycle,
//   counter=0. Counter holds across READY (stop/resume does not reset it).
//  start dropping during bring-up (RST_*, INI_*, SLP_WAIT) has no effect; bring-up always completes.
//  Delay counters are sized ceil(log2(max delay+1)); a delay value of 0 means a 1-cycle pass-through.
//  Reset mid-byte: all outputs go to reset values immediately; the shifter is reset by the same rst_n.
// TESTING
//  1. Reset, start=1 -> lcd_rst_n low for exactly 1000 cycles; first load 120000 cycles
//     after lcd_rst_n rises, data=0xCB, lcd_dc=0.
//  2. Model done 8 cycles after each load -> 47 init loads in ROM order, last one is 0x2C
//     (dc=0); 0xFF never sent; init_done rises on the 0x2C done.
//  3. Done for 0x11 -> no load for 600000 cycles, then data=0x29 dc=0.
//  4. Streaming -> pixel bytes 0xAA,0x00,0xAA,0xAA,... all dc=1; with FRAME_BYTES=6,
//     frame_tick pulses on the 6th and 12th done.
//  5. Stray done in READY/SLP_WAIT and done on the load cycle -> no state or index change;
//     start=0 mid-byte -> the byte completes, then READY, and resume continues at the next ROM index.
//  6. rst_n low during INI_WAIT -> all outputs at reset values asynchronously; restart
//     repeats the full bring-up.

Source files
------------

// File: rtl/ili9341_cmd_sequencer.sv
// ILI9341 bring-up and pixel streaming sequencer: panel reset, init ROM walk,
// then endless loop-ROM streaming, one {dc, byte} per load/done exchange.
module ili9341_cmd_sequencer #(
  parameter int N_INIT       = 48,
  parameter int N_LOOP       = 3,
  parameter int RST_LOW_CYC  = 1000,
  parameter int RST_WAIT_CYC = 120000,
  parameter int SLP_WAIT_CYC = 600000,
  parameter int FRAME_BYTES  = 153600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       rom_sel,
  output logic [5:0] rom_idx,
  input  logic [9:0] rom_word,
  output logic       load,
  output logic [7:0] data,
  output logic       lcd_dc,
  input  logic       done,
  output logic       lcd_rst_n,
  output logic       init_done,
  output logic       busy,
  output logic       frame_tick
);

  localparam int MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_DLY = (MAX_A > SLP_WAIT_CYC) ? MAX_A : SLP_WAIT_CYC;
  localparam int DLY_W   = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);
  localparam int BYTE_W  = (FRAME_BYTES < 2) ? 1 : $clog2(FRAME_BYTES);

  // A delay of N cycles keeps its state for N cycles; 0 degenerates to 1 cycle.
  localparam logic [DLY_W-1:0]  RST_LOW_LIM  = DLY_W'((RST_LOW_CYC  > 0) ? RST_LOW_CYC  - 1 : 0);
  localparam logic [DLY_W-1:0]  RST_WAIT_LIM = DLY_W'((RST_WAIT_CYC > 0) ? RST_WAIT_CYC - 1 : 0);
  localparam logic [DLY_W-1:0]  SLP_WAIT_LIM = DLY_W'((SLP_WAIT_CYC > 0) ? SLP_WAIT_CYC - 1 : 0);
  localparam logic [BYTE_W-1:0] BYTE_LAST    = BYTE_W'((FRAME_BYTES  > 0) ? FRAME_BYTES  - 1 : 0);
  localparam logic [5:0]        INIT_LAST    = 6'(N_INIT - 1);
  localparam logic [5:0]        LOOP_LAST    = 6'(N_LOOP - 1);
  localparam logic [8:0]        SLEEP_OUT    = 9'h011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_INI_LOAD,
    S_INI_WAIT,
    S_SLP_WAIT,
    S_READY,
    S_PIX_LOAD,
    S_PIX_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [DLY_W-1:0]    dly_cnt, dly_nxt;
  logic [BYTE_W-1:0]   byte_cnt, byte_nxt;
  logic                rom_sel_nxt;
  logic [5:0]          rom_idx_nxt;
  logic                lcd_rst_n_nxt;
  logic                init_done_nxt;
  logic                tick_nxt;
  logic [7:0]          data_q;
  logic                dc_q;

  // The flag bit of the ROM word is meaningful only to other consumers.
  logic unused_flag;
  assign unused_flag = rom_word[9];

  // Handshake: load is a 1-cycle strobe with {lcd_dc, data} valid; both stay
  // stable until the shifter returns a 1-cycle done. done is honoured only in
  // the WAIT states, so a done on the load cycle or while idle is dropped.
  assign load   = (state == S_INI_LOAD) || (state == S_PIX_LOAD);
  assign data   = load ? rom_word[7:0] : data_q;
  assign lcd_dc = load ? rom_word[8]   : dc_q;
  assign busy   = !((state == S_IDLE) || (state == S_READY));

  always_comb begin
    state_nxt     = state;
    dly_nxt       = '0;
    byte_nxt      = byte_cnt;
    rom_sel_nxt   = rom_sel;
    rom_idx_nxt   = rom_idx;
    lcd_rst_n_nxt = lcd_rst_n;
    init_done_nxt = init_done;
    tick_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_RST_LOW;
          lcd_rst_n_nxt = 1'b0;
        end
      end
      S_RST_LOW: begin
        if (dly_cnt == RST_LOW_LIM) begin
          state_nxt     = S_RST_WAIT;
          lcd_rst_n_nxt = 1'b1;
        end else begin
          dly_nxt = dly_cnt + 1'b1;
        end
      end
      S_RST_WAIT: begin
        if (dly_cnt == RST_WAIT_LIM) state_nxt = S_INI_LOAD;
        else                         dly_nxt   = dly_cnt + 1'b1;
      end
      S_INI_LOAD: begin
        state_nxt = S_INI_WAIT;
      end
      S_INI_WAIT: begin
        if (done) begin
          if ({dc_q, data_q} == SLEEP_OUT) begin
            state_nxt = S_SLP_WAIT;
          end else if (rom_idx == 6'd1) begin
            // Index 0 of the init ROM is a terminator and is never sent.
            state_nxt     = S_READY;
            init_done_nxt = 1'b1;
            rom_sel_nxt   = 1'b0;
            rom_idx_nxt   = LOOP_LAST;
          end else begin
            state_nxt   = S_INI_LOAD;
            rom_idx_nxt = rom_idx - 6'd1;
          end
        end
      end
      S_SLP_WAIT: begin
        if (dly_cnt == SLP_WAIT_LIM) begin
          state_nxt   = S_INI_LOAD;
          rom_idx_nxt = rom_idx - 6'd1;
        end else begin
          dly_nxt = dly_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (start) state_nxt = S_PIX_LOAD;
      end
      S_PIX_LOAD: begin
        state_nxt = S_PIX_WAIT;
      end
      S_PIX_WAIT: begin
        if (done) begin
          if (byte_cnt == BYTE_LAST) begin
            byte_nxt = '0;
            tick_nxt = 1'b1;
          end else begin
            byte_nxt = byte_cnt + 1'b1;
          end
          rom_idx_nxt = (rom_idx == 6'd0) ? LOOP_LAST : rom_idx - 6'd1;
          state_nxt   = start ? S_PIX_LOAD : S_READY;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dly_cnt    <= '0;
      byte_cnt   <= '0;
      rom_sel    <= 1'b1;
      rom_idx    <= INIT_LAST;
      lcd_rst_n  <= 1'b1;
      init_done  <= 1'b0;
      frame_tick <= 1'b0;
      data_q     <= 8'h00;
      dc_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      dly_cnt    <= dly_nxt;
      byte_cnt   <= byte_nxt;
      rom_sel    <= rom_sel_nxt;
      rom_idx    <= rom_idx_nxt;
      lcd_rst_n  <= lcd_rst_n_nxt;
      init_done  <= init_done_nxt;
      frame_tick <= tick_nxt;
      // Latch the word so it stays on the bus after rom_idx moves on.
      if (load) begin
        data_q <= rom_word[7:0];
        dc_q   <= rom_word[8];
      end
    end
  end

endmodule
